// File: rtl/maxmin_burst_tx_if.sv
// rtl/maxmin_burst_tx_if.sv - sample stream and result strobe between burst transmitter and responder
interface maxmin_burst_tx_if;
   logic       tx_valid;
   logic [7:0] tx_num;
   logic       rx_valid;
   logic [7:0] rx_max;
   logic [7:0] rx_min;

   modport master (
      output tx_valid,
      output tx_num,
      input  rx_valid,
      input  rx_max,
      input  rx_min
   );

   modport slave (
      input  tx_valid,
      input  tx_num,
      output rx_valid,
      output rx_max,
      output rx_min
   );
endinterface

// File: rtl/maxmin_burst_tx.sv
// rtl/maxmin_burst_tx.sv - max/min burst source and result checker
// Optional expected max/min tracking and comparison: MAXMIN_TX_CHECK_EN.
module maxmin_burst_tx #(
   parameter int BURST_LEN = 15,
   parameter int TIMEOUT   = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       mode,
   input  logic [7:0] seed,
   maxmin_burst_tx_if.master bus,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic       timeout_err,
   output logic [7:0] exp_max,
   output logic [7:0] exp_min
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

   state_t          state_q, state_d;
   logic            mode_q, mode_d;
   logic [7:0]      idx_q, idx_d;
   logic [CW-1:0]   wait_q, wait_d;
   logic            tx_valid_q, tx_valid_d;
   logic [7:0]      tx_num_q, tx_num_d;
   logic            busy_q;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic            toerr_q, toerr_d;
   logic [7:0]      next_num;
   logic            result_ok;

   assign next_num = mode_q ? {tx_num_q[6:0], tx_num_q[7] ^ tx_num_q[5] ^ tx_num_q[4] ^ tx_num_q[3]}
                            : tx_num_q + 8'd1;

`ifdef MAXMIN_TX_CHECK_EN
   logic [7:0] max_q, max_d;
   logic [7:0] min_q, min_d;

   assign result_ok = (bus.rx_max == max_q) && (bus.rx_min == min_q);
   assign exp_max   = max_q;
   assign exp_min   = min_q;

   always_comb begin
      max_d = max_q;
      min_d = min_q;
      if (state_q == IDLE && start) begin
         max_d = 8'h00;
         min_d = 8'hFF;
      end else if (state_q == SEND) begin
         if (tx_num_q > max_q) max_d = tx_num_q;
         if (tx_num_q < min_q) min_d = tx_num_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_q <= 8'h00;
         min_q <= 8'hFF;
      end else begin
         max_q <= max_d;
         min_q <= min_d;
      end
   end
`else
   // Handshake-only build: the returned values are deliberately not inspected.
   logic unused_rx;
   assign unused_rx = ^{bus.rx_max, bus.rx_min};
   assign result_ok = 1'b1;
   assign exp_max   = 8'h00;
   assign exp_min   = 8'hFF;
`endif

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      idx_d      = idx_q;
      wait_d     = wait_q;
      tx_valid_d = 1'b0;
      tx_num_d   = 8'h00;
      done_d     = 1'b0;
      pass_d     = pass_q;
      toerr_d    = toerr_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = SEND;
               mode_d     = mode;
               idx_d      = 8'd0;
               tx_valid_d = 1'b1;
               // An all-zero LFSR would lock up, so zero seeds start at 1.
               tx_num_d   = (mode && seed == 8'h00) ? 8'h01 : seed;
               pass_d     = 1'b0;
               toerr_d    = 1'b0;
            end
         end
         SEND: begin
            if (idx_q == 8'(BURST_LEN - 1)) begin
               state_d = WAIT;
               wait_d  = '0;
            end else begin
               idx_d      = idx_q + 8'd1;
               tx_valid_d = 1'b1;
               tx_num_d   = next_num;
            end
         end
         WAIT: begin
            if (bus.rx_valid) begin
               state_d = DONE;
               done_d  = 1'b1;
               pass_d  = result_ok;
            end else if (wait_q == CW'(TIMEOUT - 1)) begin
               state_d = DONE;
               done_d  = 1'b1;
               pass_d  = 1'b0;
               toerr_d = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         mode_q     <= 1'b0;
         idx_q      <= 8'd0;
         wait_q     <= '0;
         tx_valid_q <= 1'b0;
         tx_num_q   <= 8'h00;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         toerr_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         idx_q      <= idx_d;
         wait_q     <= wait_d;
         tx_valid_q <= tx_valid_d;
         tx_num_q   <= tx_num_d;
         busy_q     <= (state_d != IDLE);
         done_q     <= done_d;
         pass_q     <= pass_d;
         toerr_q    <= toerr_d;
      end
   end

   assign bus.tx_valid = tx_valid_q;
   assign bus.tx_num   = tx_num_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign timeout_err  = toerr_q;

endmodule

// File: tb/tb_maxmin_burst_tx.sv
// tb/tb_maxmin_burst_tx.sv - randomized self-checking bench for maxmin_burst_tx
module tb_maxmin_burst_tx;

   localparam int BL = 15;
   localparam int TO = 15;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       mode = 1'b0;
   logic [7:0] seed = 8'h00;
   logic       busy, done, pass, timeout_err;
   logic [7:0] exp_max, exp_min;

   maxmin_burst_tx_if bus ();

   maxmin_burst_tx #(.BURST_LEN(BL), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .mode        (mode),
      .seed        (seed),
      .bus         (bus.master),
      .busy        (busy),
      .done        (done),
      .pass        (pass),
      .timeout_err (timeout_err),
      .exp_max     (exp_max),
      .exp_min     (exp_min)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   logic [7:0] exp_q[$];
   logic [7:0] mdl_max, mdl_min;

   // Reference burst: closed-form counting for mode 0, feedback rule for mode 1.
   function automatic void build(input logic m, input logic [7:0] s);
      logic [7:0] v;
      exp_q.delete();
      v = (m && s == 8'h00) ? 8'h01 : s;
      for (int k = 0; k < BL; k++) begin
         if (!m) exp_q.push_back(8'((int'(s) + k) % 256));
         else begin
            exp_q.push_back(v);
            v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
         end
      end
      mdl_max = 8'h00;
      mdl_min = 8'hFF;
      foreach (exp_q[i]) begin
         if (exp_q[i] > mdl_max) mdl_max = exp_q[i];
         if (exp_q[i] < mdl_min) mdl_min = exp_q[i];
      end
   endfunction

   int low_run = 0;
   bit prev_v  = 1'b0;
   bit seen    = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (!bus.tx_valid) begin
            check("tx_num_low", {24'd0, bus.tx_num}, 32'h0);
            low_run++;
         end else begin
            if (!prev_v && seen) check("burst_gap_ge3", 32'(low_run >= 3), 32'd1);
            seen    = 1'b1;
            low_run = 0;
         end
         prev_v = bus.tx_valid;
      end
   end

   // Call just after a negedge; the following posedge is the start-sampling edge.
   task automatic run_burst(input logic m, input logic [7:0] s, input int delay,
                            input bit corrupt, input bit hold);
      int  cyc;
      bit  resp;
      logic want_pass;
      build(m, s);
      start = 1'b1;
      mode  = m;
      seed  = s;
      @(negedge clk);
      if (!hold) begin
         start = 1'b0;
         mode  = 1'($urandom);
         seed  = 8'($urandom);
      end
      for (int k = 0; k < BL; k++) begin
         check("tx_valid_send", {31'd0, bus.tx_valid}, 32'd1);
         check("tx_num_send", {24'd0, bus.tx_num}, {24'd0, exp_q[k]});
         if (k == 0) check("busy_send", {31'd0, busy}, 32'd1);
         bus.rx_valid = 1'($urandom);
         bus.rx_max   = 8'($urandom);
         bus.rx_min   = 8'($urandom);
         @(negedge clk);
      end
      bus.rx_valid = 1'b0;
      check("tx_valid_wait", {31'd0, bus.tx_valid}, 32'd0);
`ifdef MAXMIN_TX_CHECK_EN
      check("exp_max", {24'd0, exp_max}, {24'd0, mdl_max});
      check("exp_min", {24'd0, exp_min}, {24'd0, mdl_min});
`else
      check("exp_max_tied", {24'd0, exp_max}, 32'h00);
      check("exp_min_tied", {24'd0, exp_min}, 32'hFF);
`endif
      check("pass_cleared", {31'd0, pass}, 32'd0);
      check("toerr_cleared", {31'd0, timeout_err}, 32'd0);
      cyc = BL + 1;
      while (!done && cyc < BL + 100) begin
         if (cyc == BL + 1 + delay) begin
            bus.rx_valid = 1'b1;
            bus.rx_max   = corrupt ? (mdl_max ^ 8'(1 << $urandom_range(0, 7))) : mdl_max;
            bus.rx_min   = mdl_min;
         end else begin
            bus.rx_valid = 1'b0;
            bus.rx_max   = 8'($urandom);
            bus.rx_min   = 8'($urandom);
         end
         @(negedge clk);
         cyc++;
      end
      bus.rx_valid = 1'b0;
      resp = (delay < TO);
`ifdef MAXMIN_TX_CHECK_EN
      want_pass = resp && !corrupt;
`else
      want_pass = resp;
`endif
      check("done_seen", {31'd0, done}, 32'd1);
      check("done_cycle", 32'(cyc), resp ? 32'(BL + 2 + delay) : 32'(BL + 1 + TO));
      check("pass", {31'd0, pass}, {31'd0, want_pass});
      check("timeout_err", {31'd0, timeout_err}, {31'd0, !resp});
      check("busy_done", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("done_pulse", {31'd0, done}, 32'd0);
      check("busy_idle", {31'd0, busy}, 32'd0);
      check("pass_held", {31'd0, pass}, {31'd0, want_pass});
      check("toerr_held", {31'd0, timeout_err}, {31'd0, !resp});
   endtask

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_max   = 8'h00;
      bus.rx_min   = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
      check("rst_tx_num", {24'd0, bus.tx_num}, 32'h0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_pass", {31'd0, pass}, 32'd0);
      check("rst_toerr", {31'd0, timeout_err}, 32'd0);
      check("rst_exp_max", {24'd0, exp_max}, 32'h00);
      check("rst_exp_min", {24'd0, exp_min}, 32'hFF);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_burst(1'b0, 8'h10, 0, 1'b0, 1'b0);
      run_burst(1'b0, 8'hF8, 0, 1'b0, 1'b0);
      run_burst(1'b0, 8'h10, 0, 1'b1, 1'b0);
      run_burst(1'b0, 8'h10, TO, 1'b0, 1'b0);
      run_burst(1'b1, 8'h5A, TO - 1, 1'b0, 1'b0);
      run_burst(1'b1, 8'h00, 0, 1'b0, 1'b1);
      run_burst(1'b1, 8'h00, 0, 1'b0, 1'b0);

      start = 1'b1;
      mode  = 1'b0;
      seed  = 8'h40;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      check("pre_rst_valid", {31'd0, bus.tx_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_tx_num", {24'd0, bus.tx_num}, 32'h0);
      check("mid_rst_exp_max", {24'd0, exp_max}, 32'h00);
      check("mid_rst_exp_min", {24'd0, exp_min}, 32'hFF);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      run_burst(1'b0, 8'h40, 2, 1'b0, 1'b0);

      for (int i = 0; i < 20; i++) begin
         run_burst(1'($urandom), 8'($urandom), int'($urandom_range(0, TO + 1)),
                   1'($urandom), 1'b0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
